fp_operand_aligner: RTL and testbench



---
 rtl/fp_align_pkg.sv | 31 +++
 rtl/fp_unpack.sv | 27 ++
 rtl/fp_operand_aligner.sv | 123 ++++++++++++
 tb/tb_fp_operand_aligner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// fp_align_pkg: shared widths, constants and state encoding for the
// single-precision operand aligner (fp_operand_aligner and fp_unpack).
//   EXP__W       exponent width
//   FRAC__W      stored fraction width
//   MAG__W       aligned magnitude width: hidden + fraction + G,R,S
//   OP__W        aligned operand width: sign + magnitude
//   CNT__W       width of the shift counter (holds 1..MAG__W-1)
package fp_align_pkg;

  localparam int EXP__W  = 8;
  localparam int FRAC__W = 23;
  localparam int GRS__W  = 3;
  localparam int MAG__W  = FRAC__W + 4;
  localparam int OP__W   = FRAC__W + 5;
  localparam int CNT__W  = 5;

  localparam logic [EXP__W-1:0] EXP__SPECIAL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One-bit right shift that folds everything shifted out into bit 0,
  // so bit 0 always holds the OR of all bits discarded so far (sticky).
  function automatic logic [MAG__W-1:0] shr_sticky(input logic [MAG__W-1:0] m);
    return {1'b0, m[MAG__W-1:2], m[1] | m[0]};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: combinational unpack of one IEEE-754 binary32 operand.
//   i_op       packed operand {sign, exponent, fraction}
//   o_sign     sign bit
//   o_exp_eff  effective exponent (denormals and zero treated as exponent 1)
//   o_mag      {hidden, fraction, 3'b000}
//   o_special  exponent field is all ones (Inf/NaN)
module fp_unpack
  import fp_align_pkg::*;
(
  input  logic [EXP__W+FRAC__W:0] i_op,
  output logic                    o_sign,
  output logic [EXP__W-1:0]       o_exp_eff,
  output logic [MAG__W-1:0]       o_mag,
  output logic                    o_special
);

  logic [EXP__W-1:0] w_exp;
  logic              w_hidden;

  assign w_exp     = i_op[FRAC__W +: EXP__W];
  assign w_hidden  = |w_exp;
  assign o_sign    = i_op[EXP__W+FRAC__W];
  assign o_exp_eff = w_hidden ? w_exp : EXP__W'(1);
  assign o_mag     = {w_hidden, i_op[FRAC__W-1:0], {GRS__W{1'b0}}};
  assign o_special = (w_exp == EXP__SPECIAL);

endmodule

// File: rtl/fp_operand_aligner.sv
// fp_operand_aligner: pre-normalization stage of the binary32 adder.
// Captures an operand pair, right-shifts the smaller-exponent magnitude one
// bit per cycle with sticky accumulation, and presents both aligned operands
// in sign-magnitude form together with the larger exponent.
//   clk, rst__n                   clock, asynchronous active-low reset
//   in__valid / in__ready         operand pair handshake
//   op__a, op__b                  binary32 operands
//   out__valid / out__ready       result handshake
//   out__a, out__b                {sign, hidden, fraction, G, R, S}
//   out__exponent                 larger effective exponent
//   out__special                  either operand has exponent 255
module fp_operand_aligner
  import fp_align_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst__n,
  input  logic                    in__valid,
  output logic                    in__ready,
  input  logic [EXP__W+FRAC__W:0] op__a,
  input  logic [EXP__W+FRAC__W:0] op__b,
  output logic                    out__valid,
  input  logic                    out__ready,
  output logic [OP__W-1:0]        out__a,
  output logic [OP__W-1:0]        out__b,
  output logic [EXP__W-1:0]       out__exponent,
  output logic                    out__special
);

  logic              w_sign_a, w_sign_b, w_spec_a, w_spec_b;
  logic [EXP__W-1:0] w_exp_a, w_exp_b, w_exp_big, w_diff;
  logic [MAG__W-1:0] w_mag_a, w_mag_b, w_mag_small, w_mag_small_cap;
  logic              w_a_big, w_collapse, w_capture;
  state_t            w_cap_state, w_state_next;

  state_t            r_state;
  logic              r_sign_a, r_sign_b, r_special, r_shift_a;
  logic [MAG__W-1:0] r_mag_a, r_mag_b;
  logic [EXP__W-1:0] r_exp;
  logic [CNT__W-1:0] r_count;

  fp_unpack u_unpack_a (
    .i_op      (op__a),
    .o_sign    (w_sign_a),
    .o_exp_eff (w_exp_a),
    .o_mag     (w_mag_a),
    .o_special (w_spec_a)
  );

  fp_unpack u_unpack_b (
    .i_op      (op__b),
    .o_sign    (w_sign_b),
    .o_exp_eff (w_exp_b),
    .o_mag     (w_mag_b),
    .o_special (w_spec_b)
  );

  // Ties keep A as the big operand.
  assign w_a_big     = (w_exp_a >= w_exp_b);
  assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
  assign w_diff      = w_a_big ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
  assign w_mag_small = w_a_big ? w_mag_b : w_mag_a;

  // A shift of MAG__W or more leaves nothing but the sticky bit, so skip
  // the iterative shifter entirely.
  assign w_collapse      = (w_diff >= EXP__W'(MAG__W));
  assign w_mag_small_cap = w_collapse ? {{(MAG__W-1){1'b0}}, |w_mag_small} : w_mag_small;
  assign w_cap_state     = ((w_diff == '0) || w_collapse) ? DONE : SHIFT;

  assign in__ready  = rst__n & ((r_state == IDLE) | ((r_state == DONE) & out__ready));
  assign w_capture  = in__valid & in__ready;
  assign out__valid = (r_state == DONE);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_capture) w_state_next = w_cap_state;
      SHIFT:   if (r_count == CNT__W'(1)) w_state_next = DONE;
      DONE: begin
        if (out__ready) w_state_next = in__valid ? w_cap_state : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst__n) begin
    if (!rst__n) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst__n) begin
    if (!rst__n) begin
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_exp     <= '0;
      r_special <= 1'b0;
      r_count   <= '0;
      r_shift_a <= 1'b0;
    end else if (w_capture) begin
      r_sign_a  <= w_sign_a;
      r_sign_b  <= w_sign_b;
      r_mag_a   <= w_a_big ? w_mag_a : w_mag_small_cap;
      r_mag_b   <= w_a_big ? w_mag_small_cap : w_mag_b;
      r_exp     <= w_exp_big;
      r_special <= w_spec_a | w_spec_b;
      // Only meaningful for 1..26; collapsed or zero shifts never enter SHIFT.
      r_count   <= w_diff[CNT__W-1:0];
      r_shift_a <= ~w_a_big;
    end else if (r_state == SHIFT) begin
      if (r_shift_a) r_mag_a <= shr_sticky(r_mag_a);
      else           r_mag_b <= shr_sticky(r_mag_b);
      r_count <= r_count - CNT__W'(1);
    end
  end

  // A zero magnitude never carries a negative sign downstream.
  assign out__a        = {r_sign_a & (|r_mag_a), r_mag_a};
  assign out__b        = {r_sign_b & (|r_mag_b), r_mag_b};
  assign out__exponent = r_exp;
  assign out__special  = r_special;

endmodule

// File: tb/tb_fp_operand_aligner.sv
// Self-checking bench for fp_operand_aligner: directed vector table,
// hand-written back-to-back and mid-shift reset sequences, and randomized
// pairs checked against an arithmetic reference model.
// Latency is counted in clock edges including the capture edge: 1 for a
// zero or collapsed shift, d+1 (d edges after capture) for a d-bit shift.
module tb_fp_operand_aligner;

  logic        clk = 1'b0;
  logic        rst__n = 1'b0;
  logic        in__valid = 1'b0;
  logic        out__ready = 1'b0;
  logic [31:0] op__a = '0;
  logic [31:0] op__b = '0;
  logic        in__ready, out__valid, out__special;
  logic [27:0] out__a, out__b;
  logic [7:0]  out__exponent;

  int total = 0;
  int bad   = 0;

  fp_operand_aligner dut (
    .clk           (clk),
    .rst__n        (rst__n),
    .in__valid     (in__valid),
    .in__ready     (in__ready),
    .op__a         (op__a),
    .op__b         (op__b),
    .out__valid    (out__valid),
    .out__ready    (out__ready),
    .out__a        (out__a),
    .out__b        (out__b),
    .out__exponent (out__exponent),
    .out__special  (out__special)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [27:0] ea;
    logic [27:0] eb;
    logic [7:0]  ee;
    logic        esp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: exact right shift by the exponent difference, sticky
  // is set whenever any discarded bit was one.
  function automatic int eff_exp(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
  endfunction

  function automatic logic [27:0] align_one(input logic [31:0] x, input int sh);
    logic [63:0] mag, shifted;
    logic        st;
    mag     = {37'd0, (x[30:23] != 8'd0), x[22:0], 3'b000};
    shifted = mag >> sh;
    st      = ((shifted << sh) != mag);
    shifted = shifted | {63'd0, st};
    return {x[31] && (shifted != 64'd0), shifted[26:0]};
  endfunction

  task automatic run_txn(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [27:0] ea, input logic [27:0] eb, input logic [7:0] ee,
                         input logic esp, input int elat, input int hold);
    int lat;
    op__a = a;
    op__b = b;
    in__valid  = 1'b1;
    out__ready = 1'b0;
    chk({nm, ".in_ready_idle"}, 64'(in__ready), 64'd1);
    @(posedge clk); #1;
    // Keep offering junk while busy; it must not be taken.
    op__a = $urandom;
    op__b = $urandom;
    lat = 1;
    while (!out__valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    in__valid = 1'b0;
    chk({nm, ".latency"}, 64'(lat), 64'(elat));
    chk({nm, ".out_a"}, 64'(out__a), 64'(ea));
    chk({nm, ".out_b"}, 64'(out__b), 64'(eb));
    chk({nm, ".exponent"}, 64'(out__exponent), 64'(ee));
    chk({nm, ".special"}, 64'(out__special), 64'(esp));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, ".hold_in_ready"}, 64'(in__ready), 64'd0);
      chk({nm, ".hold_valid"}, 64'(out__valid), 64'd1);
      chk({nm, ".hold_a"}, 64'(out__a), 64'(ea));
      chk({nm, ".hold_b"}, 64'(out__b), 64'(eb));
    end
    out__ready = 1'b1;
    @(posedge clk); #1;
    out__ready = 1'b0;
    chk({nm, ".idle_after_handshake"}, 64'(out__valid), 64'd0);
    $display("txn %s a=%h b=%h out_a=%h out_b=%h exp=%h sp=%b lat=%0d",
             nm, a, b, ea, eb, ee, esp, lat);
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'h3F800000, 32'h3F800000, 28'h4000000, 28'h4000000, 8'h7F, 1'b0, 1, 0};
    vecs[1] = '{32'h41800000, 32'h3F800001, 28'h4000000, 28'h0400001, 8'h83, 1'b0, 5, 0};
    vecs[2] = '{32'h3F800000, 32'hB0800000, 28'h4000000, 28'h8000001, 8'h7F, 1'b0, 1, 0};
    vecs[3] = '{32'h80000000, 32'h00000001, 28'h0000000, 28'h0000008, 8'h01, 1'b0, 1, 3};
    vecs[4] = '{32'hC0400000, 32'h3F800000, 28'hE000000, 28'h2000000, 8'h80, 1'b0, 2, 1};
    vecs[5] = '{32'h3F800000, 32'h4C800000, 28'h0000001, 28'h4000000, 8'h99, 1'b0, 27, 0};
    vecs[6] = '{32'h3F800000, 32'h4D000000, 28'h0000001, 28'h4000000, 8'h9A, 1'b0, 1, 0};
    vecs[7] = '{32'hBF800000, 32'h4D000000, 28'h8000001, 28'h4000000, 8'h9A, 1'b0, 1, 2};
    vecs[8] = '{32'h80000000, 32'h40000000, 28'h0000000, 28'h4000000, 8'h80, 1'b0, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", 64'(in__ready), 64'd0);
    chk("reset.valid", 64'(out__valid), 64'd0);
    chk("reset.out_a", 64'(out__a), 64'd0);
    chk("reset.out_b", 64'(out__b), 64'd0);
    chk("reset.exponent", 64'(out__exponent), 64'd0);
    chk("reset.special", 64'(out__special), 64'd0);
    rst__n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 9; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb,
              vecs[i].ee, vecs[i].esp, vecs[i].lat, vecs[i].hold);

    // Back-to-back: second pair captured on the edge the first is consumed
    op__a = 32'h3F800000;
    op__b = 32'h3F800000;
    in__valid  = 1'b1;
    out__ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b.first_valid", 64'(out__valid), 64'd1);
    chk("b2b.first_a", 64'(out__a), 64'h4000000);
    chk("b2b.in_ready", 64'(in__ready), 64'd1);
    op__a = 32'h41800000;
    op__b = 32'h3F800001;
    @(posedge clk); #1;
    in__valid  = 1'b0;
    out__ready = 1'b0;
    chk("b2b.consumed", 64'(out__valid), 64'd0);
    lat = 1;
    while (!out__valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b.second_latency", 64'(lat), 64'd5);
    chk("b2b.second_a", 64'(out__a), 64'h4000000);
    chk("b2b.second_b", 64'(out__b), 64'h0400001);
    chk("b2b.second_exp", 64'(out__exponent), 64'h83);
    out__ready = 1'b1;
    @(posedge clk); #1;
    out__ready = 1'b0;
    $display("txn b2b second result out_b=%h lat=%0d", out__b, lat);

    // Reset in the middle of a 20-bit shift
    op__a = 32'h49800000;
    op__b = 32'h3F800000;
    in__valid = 1'b1;
    @(posedge clk); #1;
    in__valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("rst_mid.busy", 64'(out__valid), 64'd0);
    chk("rst_mid.in_ready_busy", 64'(in__ready), 64'd0);
    rst__n = 1'b0;
    #1;
    chk("rst_mid.valid", 64'(out__valid), 64'd0);
    chk("rst_mid.out_a", 64'(out__a), 64'd0);
    chk("rst_mid.out_b", 64'(out__b), 64'd0);
    chk("rst_mid.exponent", 64'(out__exponent), 64'd0);
    chk("rst_mid.in_ready", 64'(in__ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst__n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.released_ready", 64'(in__ready), 64'd1);
    chk("rst_mid.released_valid", 64'(out__valid), 64'd0);
    $display("txn reset_mid_shift discarded");
    run_txn("special", 32'h7F800000, 32'h3F800000, 28'h4000000, 28'h0000001, 8'hFF, 1'b1, 1, 0);

    // Randomized pairs against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      logic [27:0] ma, mb;
      int ea, eb, ebias, d, elat;
      logic a_big;
      a = $urandom;
      ea = int'($urandom_range(0, 255));
      ebias = ea + int'($urandom_range(0, 64)) - 32;
      if (ebias < 0) ebias = 0;
      if (ebias > 255) ebias = 255;
      b = {1'($urandom), 8'(ebias), 23'($urandom)};
      a[30:23] = 8'(ea);
      if ($urandom_range(0, 9) == 0) a[22:0] = '0;
      if ($urandom_range(0, 9) == 0) b[22:0] = '0;
      ea = eff_exp(a);
      eb = eff_exp(b);
      a_big = (ea >= eb);
      d = a_big ? (ea - eb) : (eb - ea);
      ma = align_one(a, a_big ? 0 : d);
      mb = align_one(b, a_big ? d : 0);
      elat = (d == 0 || d >= 27) ? 1 : d + 1;
      run_txn($sformatf("rnd%0d", n), a, b, ma, mb, 8'(a_big ? ea : eb),
              (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF), elat, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
